// File: rtl/shf_pkg.sv
// rtl/shf_pkg.sv - shifter operation classes and shared constants
package shf_pkg;

  localparam int SHF_CLSW = 3;

  typedef enum logic [SHF_CLSW-1:0] {
    SHF_ASH = 3'b000,
    SHF_ROT = 3'b001,
    SHF_LZ  = 3'b010,
    SHF_LO  = 3'b011,
    SHF_LSH = 3'b100
  } shf_cls_t;

endpackage

// File: rtl/shf_if.sv
// rtl/shf_if.sv - request/result bundle between the sequencer and the shifter
interface shf_if
  import shf_pkg::*;
#(
  parameter int DATASIZE = 16
) ();

  logic                ps_shf_en;
  logic [SHF_CLSW-1:0] ps_shf_cls;
  logic                ps_shf_hold;
  logic                ps_shf_clrsv;
  logic [DATASIZE-1:0] xb_dtx;
  logic [DATASIZE-1:0] xb_dty;
  logic [DATASIZE-1:0] shf_xb_dt;
  logic                shf_ps_vld;
  logic                shf_ps_sv;
  logic                shf_ps_sz;
  logic                shf_ps_svs;

  modport master (
    output ps_shf_en, ps_shf_cls, ps_shf_hold, ps_shf_clrsv, xb_dtx, xb_dty,
    input  shf_xb_dt, shf_ps_vld, shf_ps_sv, shf_ps_sz, shf_ps_svs
  );

  modport slave (
    input  ps_shf_en, ps_shf_cls, ps_shf_hold, ps_shf_clrsv, xb_dtx, xb_dty,
    output shf_xb_dt, shf_ps_vld, shf_ps_sv, shf_ps_sz, shf_ps_svs
  );

endinterface

// File: rtl/shf_lead_cnt.sv
// rtl/shf_lead_cnt.sv - counts leading bits equal to i_pol (LZ when 0, LO when 1)
module shf_lead_cnt #(
  parameter int DATASIZE = 16,
  parameter int CNTW     = $clog2(DATASIZE) + 1
) (
  input  logic [DATASIZE-1:0] i_data,
  input  logic                i_pol,
  output logic [CNTW-1:0]     o_cnt
);

  // Scanning upward lets the highest mismatching bit win the last assignment.
  always_comb begin
    o_cnt = CNTW'(DATASIZE);
    for (int i = 0; i < DATASIZE; i++) begin
      if (i_data[i] != i_pol) o_cnt = CNTW'(DATASIZE - 1 - i);
    end
  end

endmodule

// File: rtl/shf_pipe.sv
// rtl/shf_pipe.sv - two-stage shift/rotate/leading-count execution unit
module shf_pipe
  import shf_pkg::*;
#(
  parameter int DATASIZE = 16,
  parameter int CNTW     = $clog2(DATASIZE) + 1
) (
  input  logic   clk_exe,
  input  logic   reset,
  shf_if.slave   bus
);

  localparam int LOGW = $clog2(DATASIZE);

  logic                r_s1_vld;
  logic [SHF_CLSW-1:0] r_s1_cls;
  logic [DATASIZE-1:0] r_s1_rx;
  logic [DATASIZE-1:0] r_s1_ry;
  logic [DATASIZE-1:0] r_dt;
  logic                r_vld;
  logic                r_sv;
  logic                r_sz;
  logic                r_svs;

  logic                w_neg;
  logic                w_left;
  logic [DATASIZE-1:0] w_mag;
  logic                w_big;
  logic [LOGW-1:0]     w_amt;
  logic                w_rot;
  logic                w_fill;
  logic [DATASIZE-1:0] w_rx_rev;
  logic [DATASIZE-1:0] w_out_rev;
  logic [DATASIZE-1:0] w_stg [0:LOGW];
  logic [DATASIZE-1:0] w_brl_out;
  logic [DATASIZE-1:0] w_shf;
  logic [DATASIZE-1:0] w_keep;
  logic                w_lost;
  logic [CNTW-1:0]     w_cnt;
  logic [DATASIZE-1:0] w_res;
  logic                w_sv;
  logic                w_sz;

  // Unary minus of the most negative value is itself, whose upper bits make w_big true.
  assign w_neg  = r_s1_ry[DATASIZE-1];
  assign w_left = ~w_neg;
  assign w_mag  = w_neg ? -r_s1_ry : r_s1_ry;
  assign w_big  = |w_mag[DATASIZE-1:LOGW];
  assign w_amt  = w_mag[LOGW-1:0];
  assign w_rot  = (r_s1_cls == SHF_ROT);
  assign w_fill = (r_s1_cls == SHF_ASH) && w_neg && r_s1_rx[DATASIZE-1];

  // Left operations run through the same right-going barrel on bit-reversed data.
  for (genvar g = 0; g < DATASIZE; g++) begin : g_rev
    assign w_rx_rev[g]  = r_s1_rx[DATASIZE-1-g];
    assign w_out_rev[g] = w_stg[LOGW][DATASIZE-1-g];
    assign w_keep[g]    = (w_amt <= LOGW'(DATASIZE - 1 - g));
  end

  assign w_stg[0] = w_left ? w_rx_rev : r_s1_rx;

  for (genvar g = 0; g < LOGW; g++) begin : g_barrel
    logic [2*DATASIZE-1:0] w_ext;
    assign w_ext        = {(w_rot ? w_stg[g] : {DATASIZE{w_fill}}), w_stg[g]};
    assign w_stg[g+1]   = w_amt[g] ? w_ext[(1 << g) +: DATASIZE] : w_stg[g];
  end

  assign w_brl_out = w_left ? w_out_rev : w_stg[LOGW];
  assign w_shf     = (w_big && !w_rot) ? {DATASIZE{w_fill}} : w_brl_out;
  assign w_lost    = w_big ? (|r_s1_rx) : (|(r_s1_rx & ~w_keep));

  shf_lead_cnt #(
    .DATASIZE (DATASIZE),
    .CNTW     (CNTW)
  ) u_lead_cnt (
    .i_data (r_s1_rx),
    .i_pol  (r_s1_cls == SHF_LO),
    .o_cnt  (w_cnt)
  );

  always_comb begin
    w_res = '0;
    w_sv  = 1'b0;
    case (r_s1_cls)
      SHF_ASH: begin
        w_res = w_shf;
        w_sv  = w_left && (w_lost || (w_shf[DATASIZE-1] != r_s1_rx[DATASIZE-1]));
      end
      SHF_LSH: begin
        w_res = w_shf;
        w_sv  = w_left && w_lost;
      end
      SHF_ROT: w_res = w_shf;
      SHF_LZ, SHF_LO: begin
        w_res = {{(DATASIZE-CNTW){1'b0}}, w_cnt};
        w_sv  = (w_cnt == CNTW'(DATASIZE));
      end
      default: w_res = '0;
    endcase
    w_sz = (r_s1_cls <= SHF_LSH) && (w_res == '0);
  end

  always_ff @(posedge clk_exe or negedge reset) begin
    if (!reset) begin
      r_s1_vld <= 1'b0;
      r_s1_cls <= '0;
      r_s1_rx  <= '0;
      r_s1_ry  <= '0;
      r_dt     <= '0;
      r_vld    <= 1'b0;
      r_sv     <= 1'b0;
      r_sz     <= 1'b0;
      r_svs    <= 1'b0;
    end else begin
      if (!bus.ps_shf_hold) begin
        r_s1_vld <= bus.ps_shf_en;
        if (bus.ps_shf_en) begin
          r_s1_cls <= bus.ps_shf_cls;
          r_s1_rx  <= bus.xb_dtx;
          r_s1_ry  <= bus.xb_dty;
        end
        r_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_dt <= w_res;
          r_sv <= w_sv;
          r_sz <= w_sz;
        end
      end
      // A fresh overflow on the same edge outranks the clear request.
      if (!bus.ps_shf_hold && r_s1_vld && w_sv) r_svs <= 1'b1;
      else if (bus.ps_shf_clrsv)               r_svs <= 1'b0;
    end
  end

  assign bus.shf_xb_dt  = r_dt;
  assign bus.shf_ps_vld = r_vld;
  assign bus.shf_ps_sv  = r_sv;
  assign bus.shf_ps_sz  = r_sz;
  assign bus.shf_ps_svs = r_svs;

endmodule

// File: tb/tb_shf_pipe.sv
// tb/tb_shf_pipe.sv - randomized and directed checks of shf_pipe against a behavioural model
module tb_shf_pipe;
  import shf_pkg::*;

  localparam int DW = 16;

  logic clk_exe = 1'b0;
  logic reset   = 1'b0;
  always #5 clk_exe = ~clk_exe;

  shf_if #(.DATASIZE(DW)) u_if ();

  shf_pipe #(.DATASIZE(DW), .CNTW(5)) u_dut (
    .clk_exe (clk_exe),
    .reset   (reset),
    .bus     (u_if)
  );

  typedef struct {
    logic [DW-1:0] dt;
    logic          sv;
    logic          sz;
    int            tag;
  } exp_t;

  exp_t          q[$];
  int            adv;
  logic          m_vld, m_sv, m_sz, m_svs;
  logic [DW-1:0] m_dt;
  int            n_res;
  int            tests;
  int            fails;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {sv, sz, dt}; amounts are handled as plain integers.
  function automatic logic [DW+1:0] ref_op(input logic [2:0] cls, input logic [DW-1:0] rx,
                                           input logic [DW-1:0] ry);
    logic [DW-1:0]        dt;
    logic signed [DW-1:0] srx;
    logic                 sv;
    logic                 left;
    int                   mag, m, n;
    srx  = rx;
    left = !ry[DW-1];
    mag  = left ? int'(ry) : 65536 - int'(ry);
    dt   = '0;
    sv   = 1'b0;
    case (cls)
      3'd0, 3'd4: begin
        if (left) begin
          dt = (mag >= DW) ? 16'h0 : 16'(rx << mag);
          sv = (mag >= DW) ? (rx != 0) : ((32'(rx) >> (DW - mag)) != 0);
          if (cls == 3'd0 && dt[DW-1] != rx[DW-1]) sv = 1'b1;
        end else if (cls == 3'd0) begin
          dt = (mag >= DW) ? {DW{rx[DW-1]}} : 16'(srx >>> mag);
        end else begin
          dt = (mag >= DW) ? 16'h0 : 16'(rx >> mag);
        end
      end
      3'd1: begin
        m  = mag % DW;
        dt = left ? 16'((rx << m) | (rx >> (DW - m))) : 16'((rx >> m) | (rx << (DW - m)));
      end
      3'd2, 3'd3: begin
        n = 0;
        while (n < DW && rx[DW-1-n] == cls[0]) n++;
        dt = 16'(n);
        sv = (n == DW);
      end
      default: dt = '0;
    endcase
    return {sv, (cls <= 3'd4) && (dt == 0), dt};
  endfunction

  task automatic clear_model();
    q.delete();
    adv   = 0;
    m_vld = 1'b0;
    m_dt  = '0;
    m_sv  = 1'b0;
    m_sz  = 1'b0;
    m_svs = 1'b0;
  endtask

  task automatic drv(input logic en, input logic [2:0] cls, input logic [DW-1:0] rx,
                     input logic [DW-1:0] ry);
    u_if.ps_shf_en    = en;
    u_if.ps_shf_cls   = cls;
    u_if.xb_dtx       = rx;
    u_if.xb_dty       = ry;
    u_if.ps_shf_hold  = 1'b0;
    u_if.ps_shf_clrsv = 1'b0;
  endtask

  // One clock edge: model advances on the edge, outputs are compared on the falling edge.
  task automatic step();
    logic [DW+1:0] r;
    exp_t          e;
    logic          ld, hold_e;
    ld = 1'b0;
    @(posedge clk_exe);
    hold_e = u_if.ps_shf_hold;
    if (!reset) begin
      clear_model();
    end else begin
      if (!hold_e) begin
        adv++;
        if (q.size() > 0 && q[0].tag == adv - 1) begin
          e     = q.pop_front();
          m_vld = 1'b1;
          m_dt  = e.dt;
          m_sv  = e.sv;
          m_sz  = e.sz;
          ld    = 1'b1;
        end else begin
          m_vld = 1'b0;
        end
        if (u_if.ps_shf_en) begin
          r = ref_op(u_if.ps_shf_cls, u_if.xb_dtx, u_if.xb_dty);
          q.push_back('{r[DW-1:0], r[DW+1], r[DW], adv});
        end
      end
      if (ld && m_sv)             m_svs = 1'b1;
      else if (u_if.ps_shf_clrsv) m_svs = 1'b0;
    end
    @(negedge clk_exe);
    if (u_if.shf_ps_vld && !hold_e) n_res++;
    chk("vld", 32'(u_if.shf_ps_vld), 32'(m_vld));
    chk("dt",  32'(u_if.shf_xb_dt),  32'(m_dt));
    chk("sv",  32'(u_if.shf_ps_sv),  32'(m_sv));
    chk("sz",  32'(u_if.shf_ps_sz),  32'(m_sz));
    chk("svs", 32'(u_if.shf_ps_svs), 32'(m_svs));
  endtask

  task automatic op1(input logic [2:0] cls, input logic [DW-1:0] rx, input logic [DW-1:0] ry);
    drv(1'b1, cls, rx, ry);
    step();
    drv(1'b0, 3'd0, '0, '0);
    step();
  endtask

  initial begin
    int            t;
    logic [2:0]    cls;
    logic [DW-1:0] rx, ry;
    tests = 0;
    fails = 0;
    n_res = 0;
    clear_model();
    drv(1'b0, 3'd0, '0, '0);
    repeat (2) step();
    reset = 1'b1;
    step();

    drv(1'b1, SHF_ASH, 16'hF000, 16'hFFFC);
    step();
    chk("ash_lat1_vld", 32'(u_if.shf_ps_vld), 32'd0);
    drv(1'b0, 3'd0, '0, '0);
    step();
    chk("ash_vld", 32'(u_if.shf_ps_vld), 32'd1);
    chk("ash_dt",  32'(u_if.shf_xb_dt),  32'hFF00);
    chk("ash_sv",  32'(u_if.shf_ps_sv),  32'd0);
    chk("ash_sz",  32'(u_if.shf_ps_sz),  32'd0);
    op1(SHF_ROT, 16'hC000, 16'h0002);
    chk("rot_l", 32'(u_if.shf_xb_dt), 32'h0003);
    op1(SHF_ROT, 16'h8888, 16'hFFFE);
    chk("rot_r", 32'(u_if.shf_xb_dt), 32'h2222);
    op1(SHF_LZ, 16'h0000, 16'h0000);
    chk("lz_dt", 32'(u_if.shf_xb_dt), 32'h0010);
    chk("lz_sv", 32'(u_if.shf_ps_sv), 32'd1);
    op1(SHF_LO, 16'hFFA0, 16'h0000);
    chk("lo_dt", 32'(u_if.shf_xb_dt), 32'h0009);
    chk("lo_sv", 32'(u_if.shf_ps_sv), 32'd0);
    op1(SHF_LSH, 16'h8000, 16'hFFF0);
    chk("lsh_dt", 32'(u_if.shf_xb_dt), 32'h0000);
    chk("lsh_sz", 32'(u_if.shf_ps_sz), 32'd1);
    op1(3'd6, 16'h1234, 16'h0001);
    chk("rsv_dt", 32'(u_if.shf_xb_dt), 32'h0000);

    u_if.ps_shf_clrsv = 1'b1;
    step();
    chk("svs_clr", 32'(u_if.shf_ps_svs), 32'd0);
    op1(SHF_ASH, 16'h4000, 16'h0001);
    chk("ovf_dt",  32'(u_if.shf_xb_dt),  32'h8000);
    chk("ovf_sv",  32'(u_if.shf_ps_sv),  32'd1);
    chk("ovf_svs", 32'(u_if.shf_ps_svs), 32'd1);
    op1(SHF_ROT, 16'hC000, 16'h0002);
    chk("svs_keep", 32'(u_if.shf_ps_svs), 32'd1);
    drv(1'b1, SHF_ASH, 16'h4000, 16'h0001);
    step();
    drv(1'b0, 3'd0, '0, '0);
    u_if.ps_shf_clrsv = 1'b1;
    step();
    chk("svs_setwins", 32'(u_if.shf_ps_svs), 32'd1);
    u_if.ps_shf_hold = 1'b1;
    step();
    chk("svs_clr_hold", 32'(u_if.shf_ps_svs), 32'd0);
    chk("vld_in_hold",  32'(u_if.shf_ps_vld), 32'd1);
    drv(1'b0, 3'd0, '0, '0);
    step();

    n_res = 0;
    for (int k = 0; k < 8; k++) begin
      drv(1'b1, 3'($urandom_range(0, 4)), 16'($urandom), 16'(int'($urandom_range(0, 40)) - 20));
      u_if.ps_shf_hold = (k >= 3 && k <= 5);
      step();
    end
    drv(1'b0, 3'd0, '0, '0);
    repeat (3) step();
    chk("hold_nres", 32'(n_res), 32'd5);

    drv(1'b1, SHF_ASH, 16'hF000, 16'hFFFC);
    step();
    reset = 1'b0;
    #1;
    chk("rst_vld", 32'(u_if.shf_ps_vld), 32'd0);
    chk("rst_dt",  32'(u_if.shf_xb_dt),  32'd0);
    chk("rst_sv",  32'(u_if.shf_ps_sv),  32'd0);
    chk("rst_sz",  32'(u_if.shf_ps_sz),  32'd0);
    chk("rst_svs", 32'(u_if.shf_ps_svs), 32'd0);
    clear_model();
    drv(1'b0, 3'd0, '0, '0);
    step();
    reset = 1'b1;
    repeat (3) step();
    op1(SHF_LSH, 16'h0001, 16'h0003);
    chk("post_rst", 32'(u_if.shf_xb_dt), 32'h0008);

    for (int k = 0; k < 600; k++) begin
      cls = 3'($urandom_range(0, 9) > 7 ? $urandom_range(5, 7) : $urandom_range(0, 4));
      case ($urandom_range(0, 4))
        0:       rx = 16'h0000;
        1:       rx = 16'hFFFF;
        2:       rx = 16'(32'h1 << $urandom_range(0, 15)) ^ 16'($urandom_range(0, 1) ? 16'hFFFF : 16'h0);
        default: rx = 16'($urandom);
      endcase
      t = int'($urandom_range(0, 40)) - 20;
      case ($urandom_range(0, 5))
        0:       ry = 16'h8000;
        1:       ry = 16'($urandom);
        default: ry = 16'(t);
      endcase
      drv(1'($urandom_range(0, 3) != 0), cls, rx, ry);
      u_if.ps_shf_hold  = ($urandom_range(0, 6) == 0);
      u_if.ps_shf_clrsv = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
